relu_maxpool2x2: RTL and testbench
==================================

// Module: relu_maxpool2x2
// PURPOSE
//  Stage directly downstream of the partial-sum accumulator. It consumes the raster-order conv result stream
//  (conv_valid/conv_result/addr/last) for one ofmap channel, applies optional ReLU and 2x2/stride-2 max-pooling,
//  and emits pooled pixels with a compact pooled address for the ofmap write-back buffer. It has no backpressure.
// PARAMETERS
//  DATA_W      8   conv/pool data width, signed two's complement
//  SIZE_W      5   ofmap_size width (max ofmap 31x31)
//  ADDR_W      10  input pixel address width
//  PADDR_W     8   pooled address width (max 15x15=225)
//  LBUF_DEPTH  16  line-buffer entries, >= max_size/2
// PORTS
//  clk          in   1        clock, rising edge
//  rst_n        in   1        synchronous active-low reset
//  ofmap_size   in   SIZE_W   ofmap side length N; sampled on first accepted pixel of a channel
//  relu_en      in   1        1: clamp negatives to 0; sampled with ofmap_size
//  conv_valid   in   1        input pixel valid; every asserted cycle is a transfer
//  conv_result  in   DATA_W   signed conv pixel
//  addr         in   ADDR_W   pixel address row*N+col; checked only, not used for indexing
//  last         in   1        with final pixel (N-1,N-1) of the channel
//  pool_valid   out  1        pooled pixel valid, 1-cycle pulse
//  pool_data    out  DATA_W   pooled pixel
//  pool_addr    out  PADDR_W  (row/2)*(N/2)+(col/2)
//  pool_last    out  1        with final pooled pixel of the channel
//  seq_err      out  1        sticky: addr mismatch or misplaced/missing last; cleared only by reset
//  busy         out  1        channel in progress (state != IDLE)
// BEHAVIOUR
//  - Reset: all outputs 0, state IDLE, counters 0, line buffer contents don't-care.
//  - Internal row/col counters advance only on conv_valid; col wraps at N-1, then row increments. Bubbles allowed.
//  - FSM: IDLE -> ROW_EVEN on first conv_valid (latch N, relu_en). ROW_EVEN -> ROW_ODD at end of an even row.
//    ROW_ODD -> ROW_EVEN at end of an odd row. Either state -> DROP when N is odd and row N-1 begins.
//    Any state -> IDLE on the pixel carrying last.
//  - Horizontal: even col stores the pixel in hold reg; odd col computes hmax=max(hold,x), signed compare.
//    If N is odd, col N-1 is ignored.
//  - ROW_EVEN, odd col: lbuf[col>>1] <= hmax. ROW_ODD, odd col: v=max(lbuf[col>>1],hmax).
//  - Output is registered one cycle after the ROW_ODD odd-col input. pool_data = (relu_en && v<0) ? 0 : v.
//  - pool_last=1 on the output for pooled (P-1,P-1), where P=N>>1. It depends only on counters, not on input last.
//  - Every pool_valid, pool_data, pool_addr and pool_last value lasts exactly 1 cycle.
//  - Pooled pixel count per channel is exactly P*P.
//  - N<2: P=0. Pixels are consumed, no outputs, FSM returns to IDLE on last.
//  - seq_err sets when addr != row*N+col on any valid.
//  - seq_err sets when last=1 at a pixel other than (N-1,N-1). Counters still reset to IDLE.
//  - seq_err sets when (N-1,N-1) arrives with last=0. Counters wrap to 0 and stay in the channel.
//  - last arriving in the same cycle as the final odd-col compare: that output is still produced on the next
//    cycle. A new channel's first pixel may follow last back-to-back.
//  - rst_n low mid-channel clears everything at the next edge, including a pending output. No pool_valid follows.
//  - ofmap_size or relu_en changes mid-channel are ignored until IDLE.
// STRUCTURE
//  - pool_pkg: pool_state_e {IDLE, ROW_EVEN, ROW_ODD, DROP}, DATA_W/SIZE_W constants, function smax8.
//  - Sub-module pool_line_buf: LBUF_DEPTH x DATA_W register array, 1 write port, 1 async read port, no reset.
//  - Top holds FSM, counters, hold reg, output register and checker.
// TESTING
//  - N=4, relu_en=0, pixels 0..15 back-to-back, last on 15 -> outputs 5,7,13,15 at addr 0..3,
//    pool_last on 15, seq_err=0.
//  - N=4, relu_en=1, all pixels -1..-16 -> four outputs of 0. Same with relu_en=0 -> -1,-3,-9,-11.
//  - N=5, pixels 0..24 -> outputs 6,8,16,18, pool_last on 18. Row 4 and col 4 are dropped.
//    busy falls after pixel 24.
//  - N=4 with random 0-3 cycle gaps in conv_valid -> identical outputs and addrs to the first test.
//  - Reset asserted after pixel 9 of N=4, then a clean N=4 channel -> only its 4 outputs. No stale output.
//  - N=4, addr of pixel 6 sent as 7 -> seq_err=1 and stays 1; pooled data unaffected.
//    last on pixel 10 -> seq_err, FSM returns to IDLE.

Source files
------------

// File: rtl/pool_pkg.sv
// rtl/pool_pkg.sv - shared types, widths and signed max helper for the ReLU/2x2 max-pool stage
package pool_pkg;

    localparam int DATA_W = 8;
    localparam int SIZE_W = 5;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ROW_EVEN = 2'd1,
        ROW_ODD  = 2'd2,
        DROP     = 2'd3
    } pool_state_e;

    function automatic logic signed [DATA_W-1:0] smax8(
        input logic signed [DATA_W-1:0] a,
        input logic signed [DATA_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pool_line_buf.sv
// rtl/pool_line_buf.sv - line buffer holding horizontal maxima of the even row
// Ports: clk; i_wr_en/i_wr_idx/i_wr_data write port; i_rd_idx/o_rd_data asynchronous read port.
// No reset: entries are always written in the even row before the odd row reads them.
module pool_line_buf #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [AW-1:0]     i_wr_idx,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [AW-1:0]     i_rd_idx,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/relu_maxpool2x2.sv
// rtl/relu_maxpool2x2.sv - optional ReLU plus 2x2/stride-2 max-pool over a raster conv result stream
// Inputs: clk, rst_n (sync, active low), ofmap_size/relu_en (latched on first pixel of a channel),
//         conv_valid/conv_result/addr/last (raster pixel stream, no backpressure).
// Outputs: pool_valid/pool_data/pool_addr/pool_last (one-cycle pooled pixel), seq_err (sticky), busy.
module relu_maxpool2x2
    import pool_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int PADDR_W    = 8,
    parameter int LBUF_DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [SIZE_W-1:0]        ofmap_size,
    input  logic                     relu_en,
    input  logic                     conv_valid,
    input  logic signed [DATA_W-1:0] conv_result,
    input  logic [ADDR_W-1:0]        addr,
    input  logic                     last,
    output logic                     pool_valid,
    output logic signed [DATA_W-1:0] pool_data,
    output logic [PADDR_W-1:0]       pool_addr,
    output logic                     pool_last,
    output logic                     seq_err,
    output logic                     busy
);

    localparam int LB_AW = $clog2(LBUF_DEPTH);

    pool_state_e               r_state, w_state_nxt;
    logic [SIZE_W-1:0]         r_row, r_col, w_row_nxt, w_col_nxt;
    logic [SIZE_W-1:0]         r_n;
    logic                      r_relu;
    logic signed [DATA_W-1:0]  r_hold;
    logic                      r_pool_valid, r_pool_last, r_seq_err;
    logic signed [DATA_W-1:0]  r_pool_data;
    logic [PADDR_W-1:0]        r_pool_addr;

    // The first pixel of a channel is processed with the live size/relu inputs,
    // since they are only latched at that same edge.
    logic [SIZE_W-1:0]         w_n, w_nm1, w_n2, w_p, w_prow, w_pcol, w_row_inc, w_row_tgt;
    logic                      w_relu, w_end_col, w_end_row, w_final, w_col_pool, w_err;
    pool_state_e               w_cur;
    logic [ADDR_W-1:0]         w_exp_addr;
    logic signed [DATA_W-1:0]  w_hmax, w_lb_rd, w_v;
    logic                      w_lb_we, w_hold_we, w_pool_fire;
    logic [LB_AW-1:0]          w_lb_idx;

    assign w_n        = (r_state == IDLE) ? ofmap_size : r_n;
    assign w_relu     = (r_state == IDLE) ? relu_en : r_relu;
    assign w_cur      = (r_state == IDLE) ? ROW_EVEN : r_state;
    // N of 0 or 1 behaves as a single-pixel channel.
    assign w_nm1      = (w_n == '0) ? '0 : w_n - SIZE_W'(1);
    assign w_n2       = {w_n[SIZE_W-1:1], 1'b0};
    assign w_p        = w_n >> 1;
    assign w_end_col  = (r_col == w_nm1);
    assign w_end_row  = (r_row == w_nm1);
    assign w_final    = w_end_col && w_end_row;
    // An odd N leaves the last column outside every 2x2 window.
    assign w_col_pool = (r_col < w_n2);
    assign w_row_inc  = w_end_row ? '0 : r_row + SIZE_W'(1);
    assign w_row_tgt  = w_end_col ? w_row_inc : r_row;
    assign w_exp_addr = ADDR_W'(r_row) * ADDR_W'(w_n) + ADDR_W'(r_col);

    assign w_prow     = r_row >> 1;
    assign w_pcol     = r_col >> 1;
    assign w_lb_idx   = LB_AW'(w_pcol);
    assign w_hmax     = smax8(r_hold, conv_result);
    assign w_v        = smax8(w_lb_rd, w_hmax);

    assign w_hold_we   = conv_valid && !r_col[0] && w_col_pool;
    assign w_lb_we     = conv_valid && r_col[0] && w_col_pool && (w_cur == ROW_EVEN);
    assign w_pool_fire = conv_valid && r_col[0] && w_col_pool && (w_cur == ROW_ODD);

    pool_line_buf #(
        .DATA_W (DATA_W),
        .DEPTH  (LBUF_DEPTH),
        .AW     (LB_AW)
    ) u_line_buf (
        .clk       (clk),
        .i_wr_en   (w_lb_we),
        .i_wr_idx  (w_lb_idx),
        .i_wr_data (w_hmax),
        .i_rd_idx  (w_lb_idx),
        .o_rd_data (w_lb_rd)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_err       = 1'b0;
        if (conv_valid) begin
            w_err = (addr != w_exp_addr) || (last != w_final);
            if (last) begin
                w_state_nxt = IDLE;
                w_row_nxt   = '0;
                w_col_nxt   = '0;
            end else begin
                // A missing last at (N-1,N-1) wraps the counters and keeps the channel open.
                w_row_nxt = w_row_tgt;
                w_col_nxt = w_end_col ? '0 : r_col + SIZE_W'(1);
                if (w_n[0] && (w_row_tgt == w_nm1)) begin
                    w_state_nxt = DROP;
                end else if (w_row_tgt[0]) begin
                    w_state_nxt = ROW_ODD;
                end else begin
                    w_state_nxt = ROW_EVEN;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_n          <= '0;
            r_relu       <= 1'b0;
            r_hold       <= '0;
            r_pool_valid <= 1'b0;
            r_pool_data  <= '0;
            r_pool_addr  <= '0;
            r_pool_last  <= 1'b0;
            r_seq_err    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_row     <= w_row_nxt;
            r_col     <= w_col_nxt;
            r_seq_err <= r_seq_err | w_err;
            if ((r_state == IDLE) && conv_valid) begin
                r_n    <= ofmap_size;
                r_relu <= relu_en;
            end
            if (w_hold_we) begin
                r_hold <= conv_result;
            end
            r_pool_valid <= w_pool_fire;
            if (w_pool_fire) begin
                r_pool_data <= (w_relu && w_v[DATA_W-1]) ? '0 : w_v;
                r_pool_addr <= PADDR_W'(w_prow) * PADDR_W'(w_p) + PADDR_W'(w_pcol);
                r_pool_last <= (w_prow == w_p - SIZE_W'(1)) && (w_pcol == w_p - SIZE_W'(1));
            end else begin
                r_pool_data <= '0;
                r_pool_addr <= '0;
                r_pool_last <= 1'b0;
            end
        end
    end

    assign pool_valid = r_pool_valid;
    assign pool_data  = r_pool_data;
    assign pool_addr  = r_pool_addr;
    assign pool_last  = r_pool_last;
    assign seq_err    = r_seq_err;
    assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_relu_maxpool2x2.sv
// tb/tb_relu_maxpool2x2.sv - directed self-checking bench for relu_maxpool2x2
module tb_relu_maxpool2x2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [4:0]        ofmap_size;
    logic              relu_en;
    logic              conv_valid;
    logic signed [7:0] conv_result;
    logic [9:0]        addr;
    logic              last;
    logic              pool_valid;
    logic signed [7:0] pool_data;
    logic [7:0]        pool_addr;
    logic              pool_last;
    logic              seq_err;
    logic              busy;

    int n_cmp = 0;
    int n_mis = 0;

    logic signed [7:0] q_data [$];
    logic [7:0]        q_addr [$];
    logic              q_last [$];

    relu_maxpool2x2 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .ofmap_size  (ofmap_size),
        .relu_en     (relu_en),
        .conv_valid  (conv_valid),
        .conv_result (conv_result),
        .addr        (addr),
        .last        (last),
        .pool_valid  (pool_valid),
        .pool_data   (pool_data),
        .pool_addr   (pool_addr),
        .pool_last   (pool_last),
        .seq_err     (seq_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (pool_valid === 1'b1) begin
            q_data.push_back(pool_data);
            q_addr.push_back(pool_addr);
            q_last.push_back(pool_last);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        q_data.delete();
        q_addr.delete();
        q_last.delete();
    endtask

    task automatic send(input logic signed [7:0] d, input int a, input logic l);
        conv_valid  = 1'b1;
        conv_result = d;
        addr        = 10'(a);
        last        = l;
        @(posedge clk);
        #1;
        conv_valid  = 1'b0;
        last        = 1'b0;
    endtask

    task automatic idle(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    // Checks exactly four pooled outputs: given data, addr 0..3, pool_last only on the fourth.
    task automatic chk_four(input string tag, input int d0, input int d1, input int d2, input int d3);
        int ed [4];
        ed = '{d0, d1, d2, d3};
        chk({tag, "_count"}, q_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_data.size()) begin
                chk($sformatf("%s_data%0d", tag, i), q_data[i], ed[i]);
                chk($sformatf("%s_addr%0d", tag, i), {24'b0, q_addr[i]}, i);
                chk($sformatf("%s_last%0d", tag, i), {31'b0, q_last[i]}, (i == 3) ? 1 : 0);
            end
        end
        clear_q();
    endtask

    initial begin
        rst_n       = 1'b0;
        ofmap_size  = 5'd4;
        relu_en     = 1'b0;
        conv_valid  = 1'b0;
        conv_result = '0;
        addr        = '0;
        last        = 1'b0;
        idle(3);

        chk("rst_pool_valid", {31'b0, pool_valid}, 0);
        chk("rst_pool_data", pool_data, 0);
        chk("rst_pool_addr", {24'b0, pool_addr}, 0);
        chk("rst_pool_last", {31'b0, pool_last}, 0);
        chk("rst_seq_err", {31'b0, seq_err}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        rst_n = 1'b1;
        idle(1);

        // N=4 ramp, back-to-back
        for (int i = 0; i < 16; i++) begin
            send(8'(i), i, i == 15);
            if (i == 0) chk("t1_busy_after_first", {31'b0, busy}, 1);
        end
        idle(2);
        chk_four("t1", 5, 7, 13, 15);
        chk("t1_seq_err", {31'b0, seq_err}, 0);
        chk("t1_busy_end", {31'b0, busy}, 0);

        // N=4 negatives, relu on then off, channels back-to-back
        relu_en = 1'b1;
        for (int i = 0; i < 16; i++) send(8'(-(i + 1)), i, i == 15);
        relu_en = 1'b0;
        for (int i = 0; i < 16; i++) send(8'(-(i + 1)), i, i == 15);
        idle(2);
        chk("t2_count", q_data.size(), 8);
        for (int i = 0; i < 4; i++) begin
            if (i < q_data.size()) chk($sformatf("t2_relu_data%0d", i), q_data[i], 0);
        end
        q_data = q_data[4:$];
        q_addr = q_addr[4:$];
        q_last = q_last[4:$];
        chk_four("t2_norelu", -1, -3, -9, -11);

        // N=5: row 4 and col 4 dropped
        ofmap_size = 5'd5;
        for (int i = 0; i < 24; i++) send(8'(i), i, 1'b0);
        chk("t3_busy_before_last", {31'b0, busy}, 1);
        send(8'd24, 24, 1'b1);
        chk("t3_busy_after_last", {31'b0, busy}, 0);
        idle(2);
        chk_four("t3", 6, 8, 16, 18);
        chk("t3_seq_err", {31'b0, seq_err}, 0);

        // N=4 with random gaps; size change mid-channel must be ignored
        ofmap_size = 5'd4;
        for (int i = 0; i < 16; i++) begin
            send(8'(i), i, i == 15);
            if (i == 0) ofmap_size = 5'd7;
            idle($urandom_range(0, 3));
        end
        ofmap_size = 5'd4;
        idle(2);
        chk_four("t4", 5, 7, 13, 15);
        chk("t4_seq_err", {31'b0, seq_err}, 0);

        // reset mid-channel after pixel 9
        for (int i = 0; i < 10; i++) send(8'(i), i, 1'b0);
        rst_n = 1'b0;
        idle(1);
        chk("t5_busy_in_rst", {31'b0, busy}, 0);
        chk("t5_valid_in_rst", {31'b0, pool_valid}, 0);
        rst_n = 1'b1;
        clear_q();
        idle(2);
        chk("t5_no_stale", q_data.size(), 0);
        for (int i = 0; i < 16; i++) send(8'(i), i, i == 15);
        idle(2);
        chk_four("t5", 5, 7, 13, 15);

        // bad addr on pixel 6
        for (int i = 0; i < 16; i++) begin
            send(8'(i), (i == 6) ? 7 : i, i == 15);
            if (i == 5) chk("t6_err_before", {31'b0, seq_err}, 0);
            if (i == 6) chk("t6_err_set", {31'b0, seq_err}, 1);
        end
        idle(2);
        chk("t6_err_sticky", {31'b0, seq_err}, 1);
        chk_four("t6", 5, 7, 13, 15);

        // early last on pixel 10
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        chk("t7_err_cleared", {31'b0, seq_err}, 0);
        for (int i = 0; i < 11; i++) send(8'(i), i, i == 10);
        idle(2);
        chk("t7_seq_err", {31'b0, seq_err}, 1);
        chk("t7_busy", {31'b0, busy}, 0);
        chk("t7_count", q_data.size(), 2);
        if (q_data.size() >= 2) begin
            chk("t7_data0", q_data[0], 5);
            chk("t7_data1", q_data[1], 7);
        end
        clear_q();

        // N=2 final pixel without last: wraps and stays busy, then a proper channel closes it
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        ofmap_size = 5'd2;
        for (int i = 0; i < 4; i++) send(8'(10 - i), i, 1'b0);
        chk("t8_seq_err", {31'b0, seq_err}, 1);
        chk("t8_busy_wrap", {31'b0, busy}, 1);
        for (int i = 0; i < 4; i++) send(8'(i - 8), i, i == 3);
        chk("t8_busy_end", {31'b0, busy}, 0);
        idle(2);
        chk("t8_count", q_data.size(), 2);
        if (q_data.size() >= 2) begin
            chk("t8_data0", q_data[0], 10);
            chk("t8_last0", {31'b0, q_last[0]}, 1);
            chk("t8_data1", q_data[1], -5);
            chk("t8_addr1", {24'b0, q_addr[1]}, 0);
        end
        clear_q();

        // N=1: pixel consumed, no output
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        ofmap_size = 5'd1;
        send(8'd42, 0, 1'b1);
        idle(2);
        chk("t9_count", q_data.size(), 0);
        chk("t9_busy", {31'b0, busy}, 0);
        chk("t9_seq_err", {31'b0, seq_err}, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
